// File: rtl/instruction_fetch_queue.sv
// Fetch stage: drives the instruction-memory request from the PC, computes the next PC,
// and buffers fetched {pc, instr} pairs in a small FIFO toward decode.
module instruction_fetch_queue #(
    parameter int Address_width = 32,
    parameter int Data_width    = 32,
    parameter int Queue_depth   = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [Address_width-1:0] PC_current,
    output logic [Address_width-1:0] PC_next,
    output logic                     Imem_req,
    output logic [Address_width-1:0] Imem_addr,
    input  logic                     Imem_ack,
    input  logic [Data_width-1:0]    Imem_rdata,
    input  logic                     Redirect_valid,
    input  logic [Address_width-1:0] Redirect_target,
    input  logic                     Decode_ready,
    output logic                     Fetch_valid,
    output logic [Data_width-1:0]    Fetch_instr,
    output logic [Address_width-1:0] Fetch_pc,
    output logic                     Fetch_error
);
    localparam int PW = (Queue_depth > 1) ? $clog2(Queue_depth) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {START, RUN, FULL, ERROR} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;

    logic [Data_width-1:0]    entry_instr_q [Queue_depth];
    logic [Address_width-1:0] entry_pc_q    [Queue_depth];

    logic redirect, misaligned, push, pop;

    // Redirects are dead once the error state is entered; only reset recovers.
    assign redirect    = Redirect_valid && (state_q != ERROR);
    assign misaligned  = (Redirect_target[1:0] != 2'b00);
    assign Imem_req    = (state_q == RUN) && (count_q < CW'(Queue_depth));
    assign Imem_addr   = PC_current;
    assign push        = Imem_req && Imem_ack && !Redirect_valid;
    assign Fetch_valid = (count_q != '0) && (state_q != ERROR);
    assign pop         = Fetch_valid && Decode_ready;
    assign Fetch_instr = Fetch_valid ? entry_instr_q[rd_ptr_q] : '0;
    assign Fetch_pc    = Fetch_valid ? entry_pc_q[rd_ptr_q] : '0;
    assign Fetch_error = (state_q == ERROR);

    always_comb begin
        PC_next = PC_current;
        if (!RST)
            PC_next = '0;
        else if (redirect)
            PC_next = misaligned ? PC_current : Redirect_target;
        else if (push)
            PC_next = PC_current + Address_width'(4);
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        case (state_q)
            START:   state_d = RUN;
            RUN:     if (push && !pop && count_q == CW'(Queue_depth - 1)) state_d = FULL;
            FULL:    if (pop) state_d = RUN;
            default: state_d = ERROR;
        endcase
        // A redirect flushes everything, swallowing any same-cycle push or pop.
        if (redirect) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            state_d  = misaligned ? ERROR : RUN;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= START;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Payload storage needs no reset: outputs are gated by the count.
    always_ff @(posedge CLK) begin
        if (push) begin
            entry_instr_q[wr_ptr_q] <= Imem_rdata;
            entry_pc_q[wr_ptr_q]    <= PC_current;
        end
    end
endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Scoreboard bench for instruction_fetch_queue: the bench plays PC register and
// instruction memory, and predicts requests, queue contents and next PC.
module tb_instruction_fetch_queue;
    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] PC_current;
    logic [31:0] PC_next;
    logic        Imem_req;
    logic [31:0] Imem_addr;
    logic        Imem_ack;
    logic [31:0] Imem_rdata;
    logic        Redirect_valid;
    logic [31:0] Redirect_target;
    logic        Decode_ready;
    logic        Fetch_valid;
    logic [31:0] Fetch_instr;
    logic [31:0] Fetch_pc;
    logic        Fetch_error;

    instruction_fetch_queue dut (
        .CLK(CLK), .RST(RST), .PC_current(PC_current), .PC_next(PC_next),
        .Imem_req(Imem_req), .Imem_addr(Imem_addr), .Imem_ack(Imem_ack),
        .Imem_rdata(Imem_rdata), .Redirect_valid(Redirect_valid),
        .Redirect_target(Redirect_target), .Decode_ready(Decode_ready),
        .Fetch_valid(Fetch_valid), .Fetch_instr(Fetch_instr), .Fetch_pc(Fetch_pc),
        .Fetch_error(Fetch_error)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        sb[$];
    int          nvec = 0;
    int          nerr = 0;
    logic        started;
    logic        err_m;
    logic [31:0] pc;

    assign PC_current = pc;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0] ^ 16'hA5C3, ~a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h expected 0x%08h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        sb.delete();
        err_m   = 1'b0;
        started = 1'b0;
        pc      = 32'h0;
    endtask

    task automatic do_reset();
        RST = 1'b0;
        model_clear();
        #1;
        chk("rst_vld", {31'b0, Fetch_valid}, 32'h0);
        chk("rst_req", {31'b0, Imem_req}, 32'h0);
        chk("rst_err", {31'b0, Fetch_error}, 32'h0);
        chk("rst_pcn", PC_next, 32'h0);
        chk("rst_fpc", Fetch_pc, 32'h0);
        chk("rst_fin", Fetch_instr, 32'h0);
        repeat (2) @(posedge CLK);
        #1 RST = 1'b1;
    endtask

    task automatic tick(input logic ack, input logic rdy, input logic rv, input logic [31:0] tgt);
        logic        exp_req, exp_vld, rv_eff, push, pop;
        logic [31:0] exp_next;
        Imem_ack        = ack;
        Decode_ready    = rdy;
        Redirect_valid  = rv;
        Redirect_target = tgt;
        Imem_rdata      = memf(pc);
        exp_req  = started && !err_m && (sb.size() < 4);
        exp_vld  = (sb.size() != 0);
        rv_eff   = rv && !err_m;
        push     = exp_req && ack && !rv;
        pop      = exp_vld && rdy;
        exp_next = rv_eff ? ((tgt[1:0] == 2'b00) ? tgt : pc) : (push ? pc + 32'd4 : pc);
        @(negedge CLK);
        chk("imem_req",  {31'b0, Imem_req}, {31'b0, exp_req});
        chk("imem_addr", Imem_addr, pc);
        chk("fetch_vld", {31'b0, Fetch_valid}, {31'b0, exp_vld});
        chk("fetch_pc",  Fetch_pc,    exp_vld ? sb[0].pc : 32'h0);
        chk("fetch_ins", Fetch_instr, exp_vld ? sb[0].instr : 32'h0);
        chk("fetch_err", {31'b0, Fetch_error}, {31'b0, err_m});
        chk("pc_next",   PC_next, exp_next);
        if (rv_eff) begin
            sb.delete();
            if (tgt[1:0] != 2'b00) err_m = 1'b1;
        end else begin
            if (pop)  void'(sb.pop_front());
            if (push) sb.push_back('{pc: pc, instr: memf(pc)});
        end
        started = 1'b1;
        @(posedge CLK);
        #1 pc = exp_next;
    endtask

    initial begin
        Imem_ack = 0; Decode_ready = 0; Redirect_valid = 0;
        Redirect_target = 0; Imem_rdata = 0;

        // Streaming fetch, then a memory stall while decode drains.
        do_reset();
        repeat (6) tick(1, 1, 0, 0);
        repeat (3) tick(0, 1, 0, 0);
        repeat (2) tick(1, 1, 0, 0);

        // Backpressure: four pushes fill the queue, one pop frees one slot.
        do_reset();
        repeat (7) tick(1, 0, 0, 0);
        chk("full_pc_hold", pc, 32'h10);
        tick(1, 1, 0, 0);
        repeat (3) tick(1, 0, 0, 0);
        repeat (5) tick(1, 1, 0, 0);

        // Aligned redirect with two queued entries and a same-cycle completion.
        do_reset();
        repeat (3) tick(1, 0, 0, 0);
        tick(1, 1, 1, 32'h400);
        chk("redir_addr", pc, 32'h400);
        repeat (4) tick(1, 1, 0, 0);

        // Misaligned redirect: sticky error, later redirects ignored.
        tick(1, 0, 1, 32'h402);
        repeat (3) tick(1, 1, 1, 32'h800);
        repeat (2) tick(1, 1, 0, 0);
        do_reset();
        repeat (3) tick(1, 1, 0, 0);

        // Address wrap, then asynchronous reset while the queue holds data.
        do_reset();
        tick(1, 0, 0, 0);
        pc = 32'hFFFF_FFFC;
        tick(1, 0, 0, 0);
        tick(1, 1, 0, 0);
        tick(1, 0, 0, 0);
        chk("pre_rst_vld", {31'b0, Fetch_valid}, 32'h1);
        #2 RST = 1'b0;
        #1;
        chk("async_vld", {31'b0, Fetch_valid}, 32'h0);
        chk("async_req", {31'b0, Imem_req}, 32'h0);
        chk("async_pcn", PC_next, 32'h0);
        model_clear();
        @(posedge CLK);
        #1 RST = 1'b1;
        repeat (4) tick(1, 1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/instruction_fetch_queue.md
Name: instruction_fetch_queue

Overview:
- Fetch stage directly downstream of the program counter register; closes the PC loop.
- Takes the current PC and drives the instruction-memory request. Computes the value loaded into the PC on the next edge: hold, PC+4, or redirect target.
- Buffers fetched instructions with their PCs in a small FIFO toward decode, using a valid/ready handshake.

Parameters:
- Address_width, 32, PC and instruction-memory address width.
- Data_width, 32, instruction width.
- Queue_depth, 4, FIFO entries; power of two, at least 2.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-low.
- PC_current  in  Address_width  PC register output.
- PC_next  out  Address_width  PC register input, combinational.
- Imem_req  out  1  fetch request.
- Imem_addr  out  Address_width  fetch address; always equals PC_current.
- Imem_ack  in  1  request completes in any cycle where Imem_req and Imem_ack are both high.
- Imem_rdata  in  Data_width  instruction; valid in the completing cycle.
- Redirect_valid  in  1  branch/jump taken, from a later stage.
- Redirect_target  in  Address_width  new fetch address.
- Decode_ready  in  1  decode accepts the head entry.
- Fetch_valid  out  1  FIFO not empty.
- Fetch_instr  out  Data_width  head instruction.
- Fetch_pc  out  Address_width  head PC.
- Fetch_error  out  1  misaligned redirect seen; sticky.

Behaviour:
- Reset (RST low, asynchronous):
  - state = START; FIFO count, read pointer and write pointer = 0.
  - Fetch_valid, Fetch_instr, Fetch_pc, Fetch_error = 0; Imem_req = 0.
  - PC_next forced to 0 while RST is low.
- FSM states:
  - START: Imem_req = 0. Goes to RUN unconditionally on the next edge.
  - RUN: Imem_req = 1 when registered count < Queue_depth. Goes to FULL when a push makes count = Queue_depth.
  - FULL: Imem_req = 0. Goes back to RUN on any pop.
  - ERROR: Imem_req = 0; Fetch_error = 1. Left only by reset.
- Push: Imem_req && Imem_ack && !Redirect_valid. Writes {PC_current, Imem_rdata} at the write pointer; count + 1. A push never occurs while full.
- Pop: Fetch_valid && Decode_ready. Read pointer + 1; count - 1. The head is read combinationally from the read pointer. Fetch_instr and Fetch_pc are 0 when the FIFO is empty.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Pointers wrap modulo Queue_depth.
- PC_next priority:
  - Redirect_valid = 1 (valid in RUN/FULL/START): PC_next = Redirect_target.
  - Else on push: PC_next = PC_current + 4, modulo 2^Address_width, so 0xFFFFFFFC wraps to 0x00000000.
  - Else: PC_next = PC_current (hold).
- Redirect_valid with Redirect_target[1:0] == 00:
  - FIFO flushed next edge (count and pointers = 0); state goes to RUN.
  - A memory completion in the same cycle is discarded.
  - A same-cycle pop is absorbed by the flush.
- Redirect_valid with Redirect_target[1:0] != 00:
  - state goes to ERROR; FIFO flushed; PC_next = PC_current.
- In ERROR: Redirect_valid ignored; PC_next = PC_current; Fetch_valid = 0.
- Redirect_valid is ignored while RST is low.
- Latency:
  - First request is issued in the cycle after START.
  - A push in cycle N gives Fetch_valid = 1 in cycle N+1.
  - Sustained throughput with Imem_ack = 1: one instruction per cycle.
- Reset asserted mid-operation: FIFO contents are lost; all outputs return to their reset values immediately.

Test Plan:
- Reset release, Imem_ack = 1, Decode_ready = 1 -> Imem_addr sequence 0x0, 0x4, 0x8. Fetch_pc lags one cycle, with Fetch_instr matching the memory model.
- Decode_ready = 0, Imem_ack = 1 -> exactly 4 pushes (PCs 0x0–0xC); Imem_req drops; PC_next holds 0x10. Then one Decode_ready pulse -> one further fetch at 0x10.
- Imem_ack low for 3 cycles -> Imem_req and Imem_addr stable; PC_next = PC_current; no push.
- Redirect_valid = 1, target 0x400, with 2 entries queued and a completion in the same cycle -> FIFO empty next cycle, completion discarded, next Imem_addr = 0x400.
- Redirect target 0x402 -> Fetch_error = 1 and Imem_req = 0 permanently; a later valid redirect is ignored until RST pulses low.
- PC_current = 0xFFFFFFFC with ack -> PC_next = 0x00000000. Assert RST mid-stream -> Fetch_valid = 0 asynchronously.
